// File: rtl/vip_pkg.sv
// Shared constants and helpers for the VIP window generators.
// Counter widths and border-policy codes.
package vip_pkg;

  localparam int BORDER_ZERO      = 0;
  localparam int BORDER_REPLICATE = 1;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vip_line_buffer.sv
// Single-port line RAM, read-before-write.
// rdata shows the old word at addr during a write cycle.
module vip_line_buffer
  import vip_pkg::*;
#(
  parameter int DEPTH  = 480,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [cnt_w(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/vip_matrix_generate_3x3.sv
// 3x3 sliding window over a raster stream, 2-clk latency.
// MATRIX_BORDER_REPLICATE_EN: replicate edge taps, else zero.
module vip_matrix_generate_3x3
  import vip_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 480,
  parameter int IMG_VDISP = 272
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_data,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33,
  output logic              matrix_window_valid,
  output logic              line_overflow
);

  localparam int CW = cnt_w(IMG_HDISP + 1);
  localparam int AW = cnt_w(IMG_HDISP);
  localparam int RW = cnt_w(IMG_VDISP);
`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam int BORDER = BORDER_REPLICATE;
`else
  localparam int BORDER = BORDER_ZERO;
`endif
  localparam logic [CW-1:0] HMAX  = CW'(IMG_HDISP);
  localparam logic [RW-1:0] RLAST = RW'(IMG_VDISP - 1);

  logic              vs_prev, hr_prev, armed, ovf_done;
  logic [CW-1:0]     col_cnt, col_eff;
  logic [RW-1:0]     row_cnt, row_eff;
  logic              vs_rise, en, vs_g, hr_g, ck_g;
  logic              hr_fall, pix_any, in_rng, pix, ovf;
  logic [DATA_W-1:0] l1_rd, l2_rd;

  // Until a real vsync edge follows reset, inputs are ignored.
  assign vs_rise = per_frame_vsync & ~vs_prev;
  assign en      = armed | vs_rise;
  assign vs_g    = per_frame_vsync & en;
  assign hr_g    = per_frame_href & en;
  assign ck_g    = per_frame_clken & en;
  assign hr_fall = hr_prev & ~hr_g;
  assign col_eff = vs_rise ? '0 : col_cnt;
  assign row_eff = vs_rise ? '0 : row_cnt;
  assign pix_any = hr_g & ck_g;
  assign in_rng  = col_eff < HMAX;
  assign pix     = pix_any & in_rng;
  assign ovf     = pix_any & ~in_rng & ~ovf_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev  <= 1'b1;
      hr_prev  <= 1'b0;
      armed    <= 1'b0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      ovf_done <= 1'b0;
    end else begin
      vs_prev <= per_frame_vsync;
      hr_prev <= hr_g;
      armed   <= en;
      if (pix_any)
        col_cnt <= in_rng ? col_eff + 1'b1 : col_eff;
      else if (hr_fall)
        col_cnt <= '0;
      else
        col_cnt <= col_eff;
      if (vs_rise)
        row_cnt <= '0;
      else if (hr_fall && row_cnt != RLAST)
        row_cnt <= row_cnt + 1'b1;
      if (ovf)
        ovf_done <= 1'b1;
      else if (hr_fall || vs_rise)
        ovf_done <= 1'b0;
    end
  end

  vip_line_buffer #(
    .DEPTH (IMG_HDISP),
    .DATA_W(DATA_W)
  ) u_line0 (
    .clk  (clk),
    .we   (pix),
    .addr (col_eff[AW-1:0]),
    .wdata(per_img_data),
    .rdata(l1_rd)
  );

  vip_line_buffer #(
    .DEPTH (IMG_HDISP),
    .DATA_W(DATA_W)
  ) u_line1 (
    .clk  (clk),
    .we   (pix),
    .addr (col_eff[AW-1:0]),
    .wdata(l1_rd),
    .rdata(l2_rd)
  );

  logic              vs_d1, hr_d1, ck_d1;
  logic              pix_d1, ovf_d1, val_d1;
  logic [DATA_W-1:0] din_d1, l1_d1, l2_d1;
  logic [RW-1:0]     row_d1, row_m;
  logic [CW-1:0]     col_d1, col_m;
  logic [DATA_W-1:0] w [3][3];
  logic [DATA_W-1:0] m [3][3];

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d1  <= 1'b0;
      hr_d1  <= 1'b0;
      ck_d1  <= 1'b0;
      pix_d1 <= 1'b0;
      ovf_d1 <= 1'b0;
      val_d1 <= 1'b0;
      din_d1 <= '0;
      l1_d1  <= '0;
      l2_d1  <= '0;
      row_d1 <= '0;
      col_d1 <= '0;
    end else begin
      vs_d1  <= vs_g;
      hr_d1  <= hr_g;
      ck_d1  <= ck_g;
      pix_d1 <= pix;
      ovf_d1 <= ovf;
      val_d1 <= pix && row_eff >= RW'(2)
                    && col_eff >= CW'(2);
      din_d1 <= per_img_data;
      l1_d1  <= l1_rd;
      l2_d1  <= l2_rd;
      row_d1 <= row_eff;
      col_d1 <= col_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_frame_vsync  <= 1'b0;
      matrix_frame_href   <= 1'b0;
      matrix_frame_clken  <= 1'b0;
      matrix_window_valid <= 1'b0;
      line_overflow       <= 1'b0;
      row_m               <= '0;
      col_m               <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] <= '0;
    end else begin
      matrix_frame_vsync  <= vs_d1;
      matrix_frame_href   <= hr_d1;
      matrix_frame_clken  <= ck_d1;
      matrix_window_valid <= val_d1;
      line_overflow       <= ovf_d1;
      if (!hr_d1) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[i][j] <= '0;
      end else if (pix_d1) begin
        for (int i = 0; i < 3; i++) begin
          w[i][0] <= w[i][1];
          w[i][1] <= w[i][2];
        end
        w[0][2] <= l2_d1;
        w[1][2] <= l1_d1;
        w[2][2] <= din_d1;
        row_m   <= row_d1;
        col_m   <= col_d1;
      end
    end
  end

  // Map each tap to its nearest in-image source tap.
  logic [1:0] ri, cj;
  always_comb begin
    ri = 2'd0;
    cj = 2'd0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ri = 2'(i);
        cj = 2'(j);
        if (row_m == '0)
          ri = 2'd2;
        else if (row_m == RW'(1) && i == 0)
          ri = 2'd1;
        if (col_m == '0)
          cj = 2'd2;
        else if (col_m == CW'(1) && j == 0)
          cj = 2'd1;
        if (BORDER == BORDER_REPLICATE)
          m[i][j] = w[ri][cj];
        else if (ri != 2'(i) || cj != 2'(j))
          m[i][j] = '0;
        else
          m[i][j] = w[i][j];
      end
    end
  end

  assign matrix_p11 = m[0][0];
  assign matrix_p12 = m[0][1];
  assign matrix_p13 = m[0][2];
  assign matrix_p21 = m[1][0];
  assign matrix_p22 = m[1][1];
  assign matrix_p23 = m[1][2];
  assign matrix_p31 = m[2][0];
  assign matrix_p32 = m[2][1];
  assign matrix_p33 = m[2][2];

endmodule

// File: tb/tb_vip_matrix_generate_3x3.sv
// Scoreboard bench for vip_matrix_generate_3x3 (8x4 image).
// Reference windows are cut from a frame image array.
module tb_vip_matrix_generate_3x3;

  localparam int DW = 8;
  localparam int H  = 8;
  localparam int V  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [DW-1:0] d = '0;
  logic          m_vs, m_hr, m_ck, m_val, m_ovf;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23;
  logic [DW-1:0] p31, p32, p33;

  always #5 clk = ~clk;

  vip_matrix_generate_3x3 #(
    .DATA_W   (DW),
    .IMG_HDISP(H),
    .IMG_VDISP(V)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .per_frame_vsync    (vs),
    .per_frame_href     (hr),
    .per_frame_clken    (ck),
    .per_img_data       (d),
    .matrix_frame_vsync (m_vs),
    .matrix_frame_href  (m_hr),
    .matrix_frame_clken (m_ck),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33),
    .matrix_window_valid(m_val),
    .line_overflow      (m_ovf)
  );

  typedef logic [0:8][DW-1:0] win_t;
  typedef struct packed {
    win_t t;
    logic val;
    logic ovf;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0] img [V][H];
  logic mv_prev = 1'b1, mh_prev = 1'b0;
  logic marmed = 1'b0, movfd = 1'b0;
  int   mrow = 0, mcol = 0;
  win_t cur = '0;
  logic [2:0] g = '0, ed1 = '0, ed2 = '0;

  function automatic win_t window(int r, int c);
    win_t w;
    int rr, cc;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        rr = r - 2 + i;
        cc = c - 2 + j;
`ifdef MATRIX_BORDER_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (cc < 0) cc = 0;
        w[i*3+j] = img[rr][cc];
`else
        if (rr < 0 || cc < 0) w[i*3+j] = '0;
        else w[i*3+j] = img[rr][cc];
`endif
      end
    return w;
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] got,
                     input logic [71:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, got, want, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic h,
                     input logic k, input logic [DW-1:0] px,
                     input logic r);
    logic rise, e, gh, gk;
    exp_t ne;
    vs = v; hr = h; ck = k; d = px; rst = r;
    if (r) begin
      mv_prev = 1'b1; mh_prev = 1'b0;
      marmed = 1'b0; movfd = 1'b0;
      mrow = 0; mcol = 0; cur = '0; g = '0;
    end else begin
      rise = v & ~mv_prev;
      e    = marmed | rise;
      gh   = h & e;
      gk   = k & e;
      g    = {v & e, gh, gk};
      if (rise) begin
        mrow = 0; mcol = 0; movfd = 1'b0;
      end
      if (!gh) cur = '0;
      if (gh && gk) begin
        if (mcol < H) begin
          img[mrow][mcol] = px;
          cur    = window(mrow, mcol);
          ne.t   = cur;
          ne.val = (mrow >= 2 && mcol >= 2);
          ne.ovf = 1'b0;
        end else begin
          ne.t   = cur;
          ne.val = 1'b0;
          ne.ovf = ~movfd;
          movfd  = 1'b1;
        end
        q.push_back(ne);
        mcol++;
      end
      if (mh_prev && !gh) begin
        mcol = 0; movfd = 1'b0;
        if (!rise && mrow < V - 1) mrow++;
      end
      mh_prev = gh; mv_prev = v; marmed = e;
    end
    @(posedge clk);
    #1;
    if (r) q.delete();
  endtask

  // ckm: 0 continuous, 1 toggling, 2 random
  task automatic line(int r, int npix, int ckm,
                      int dm, int rst_col);
    int   c = 0;
    logic tog = 1'b1;
    logic k;
    logic [DW-1:0] px;
    while (c < npix) begin
      case (ckm)
        0:       k = 1'b1;
        1:       k = tog;
        default: k = ($urandom_range(0, 3) != 0);
      endcase
      tog = ~tog;
      px = dm != 0 ? DW'($urandom) : DW'(r * 16 + c);
      if (k && c == rst_col) cyc(1'b1, 1'b1, 1'b1, px, 1'b1);
      else cyc(1'b1, 1'b1, k, px, 1'b0);
      if (k) c++;
    end
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic frame(int ckm, int dm, int tog_row,
                       int ovf_row, int rst_row, int rst_col);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int r = 0; r < V; r++)
      line(r, (r == ovf_row) ? 10 : H,
           (r == tog_row) ? 1 : ckm, dm,
           (r == rst_row) ? rst_col : -1);
  endtask

  always @(posedge clk) begin
    ed2 <= rst ? 3'b000 : ed1;
    ed1 <= rst ? 3'b000 : g;
  end

  exp_t e_m;
  win_t last = '0;
  win_t got;
  always @(negedge clk) begin
    got = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    chk("sync", {m_vs, m_hr, m_ck}, ed2);
    if (m_hr && m_ck) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pixel: got clken want none");
      end else begin
        e_m = q.pop_front();
        chk("window", got, e_m.t);
        chk("valid", m_val, e_m.val);
        chk("overflow", m_ovf, e_m.ovf);
        last = e_m.t;
      end
    end else if (m_hr) begin
      chk("hold", got, last);
      chk("valid_gap", m_val, 0);
      chk("ovf_gap", m_ovf, 0);
    end else begin
      chk("idle", got, 0);
      chk("valid_idle", m_val, 0);
      chk("ovf_idle", m_ovf, 0);
      last = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    frame(0, 0, -1, -1, -1, -1);
    frame(0, 0, 2, -1, -1, -1);
    frame(0, 0, -1, 1, -1, -1);
    frame(0, 0, -1, -1, 2, 5);
    frame(0, 0, -1, -1, -1, -1);
    // vsync restart in the middle of a line
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    line(0, H, 0, 0, -1);
    for (int c = 0; c < 3; c++)
      cyc(1'b1, 1'b1, 1'b1, DW'(8'hA0 + c), 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int r = 0; r < V; r++) line(r, H, 0, 1, -1);
    for (int f = 0; f < 8; f++)
      frame(2, 1, -1, int'($urandom_range(0, V)), -1, -1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("drain", 72'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
